uart_loopback_ctrl: RTL and testbench

//  Parametrised RX->TX loopback/bridge controller between the Uart_Drive user side and itself.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_sync_fifo.sv | 56 +++++
 rtl/uart_loopback_ctrl.sv | 136 +++++++++++++
 tb/tb_uart_loopback_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART RX->TX loopback controller.
// The TX FSM state type and the mode encodings live here.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        SEND    = 3'd2,
        WAIT_LO = 3'd3,
        WAIT_HI = 3'd4
    } tx_state_e;

    localparam logic UART_MODE_BYTE = 1'b0;
    localparam logic UART_MODE_LINE = 1'b1;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with a registered read port and an explicit occupancy counter.
// Writes into a full FIFO and reads from an empty FIFO are ignored.
module uart_sync_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 64
) (
    input  logic                     w_user_clk,
    input  logic                     w_user_rst,
    input  logic                     wr_en,
    input  logic [DW-1:0]            din,
    input  logic                     rd_en,
    output logic [DW-1:0]            dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_wr;
    logic          do_rd;

    assign full  = (level == (AW+1)'(DEPTH));
    assign empty = (level == '0);
    assign do_wr = wr_en & ~full;
    assign do_rd = rd_en & ~empty;

    // Storage is not reset; the pointers and level define what is valid.
    always_ff @(posedge w_user_clk) begin
        if (do_wr) mem[wr_ptr] <= din;
    end

    always_ff @(posedge w_user_clk or posedge w_user_rst) begin
        if (w_user_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            dout   <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
                dout   <= mem[rd_ptr];
            end
            case ({do_wr, do_rd})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_loopback_ctrl.sv
// RX->TX loopback controller: buffers received bytes and re-issues them to the TX side
// with a valid/ready handshake, in byte (echo) or line (hold until terminator) mode.
module uart_loopback_ctrl
    import uart_pkg::*;
#(
    parameter int P_DATA_WIDTH  = 8,
    parameter int P_FIFO_DEPTH  = 64,
    parameter int P_ACK_TIMEOUT = 1024,
    parameter int P_CNT_WIDTH   = 16
) (
    input  logic                           w_user_clk,
    input  logic                           w_user_rst,
    input  logic [P_DATA_WIDTH-1:0]        i_rx_data,
    input  logic                           i_rx_valid,
    output logic [P_DATA_WIDTH-1:0]        o_tx_data,
    output logic                           o_tx_valid,
    input  logic                           i_tx_ready,
    input  logic                           i_mode,
    input  logic [P_DATA_WIDTH-1:0]        i_term_char,
    output logic [$clog2(P_FIFO_DEPTH):0]  o_fifo_level,
    output logic [P_CNT_WIDTH-1:0]         o_overflow_cnt,
    output logic [P_CNT_WIDTH-1:0]         o_timeout_cnt,
    output logic                           o_busy
);

    localparam int AW = $clog2(P_FIFO_DEPTH);
    localparam int TW = $clog2(P_ACK_TIMEOUT);

    tx_state_e               state;
    logic [P_DATA_WIDTH-1:0] fifo_dout;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [AW:0]             fifo_level;
    logic                    rd_en;
    logic                    wr_acc;
    logic                    drain_en;
    logic                    term_in;
    logic                    term_out;
    logic [AW:0]             term_pending;
    logic                    flush;
    logic [TW-1:0]           tmo_cnt;

    uart_sync_fifo #(
        .DW    (P_DATA_WIDTH),
        .DEPTH (P_FIFO_DEPTH)
    ) u_fifo (
        .w_user_clk (w_user_clk),
        .w_user_rst (w_user_rst),
        .wr_en      (i_rx_valid),
        .din        (i_rx_data),
        .rd_en      (rd_en),
        .dout       (fifo_dout),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .level      (fifo_level)
    );

    assign wr_acc       = i_rx_valid & ~fifo_full;
    assign drain_en     = (i_mode == UART_MODE_BYTE) | (term_pending != '0) | flush;
    assign rd_en        = (state == IDLE) & ~fifo_empty & drain_en & i_tx_ready;
    assign o_fifo_level = fifo_level;
    assign o_busy       = (state != IDLE) | ~fifo_empty;

    // Terminators are counted in both modes so a byte->line switch sees a consistent count.
    assign term_in  = wr_acc & (i_rx_data == i_term_char);
    assign term_out = (state == SEND) & (o_tx_data == i_term_char);

    always_ff @(posedge w_user_clk or posedge w_user_rst) begin
        if (w_user_rst) begin
            term_pending <= '0;
        end else begin
            case ({term_in, term_out})
                2'b10:   term_pending <= term_pending + 1'b1;
                2'b01:   if (term_pending != '0) term_pending <= term_pending - 1'b1;
                default: term_pending <= term_pending;
            endcase
        end
    end

    // A full FIFO in line mode can never see its terminator, so drain it all.
    always_ff @(posedge w_user_clk or posedge w_user_rst) begin
        if (w_user_rst)      flush <= 1'b0;
        else if (fifo_full)  flush <= 1'b1;
        else if (fifo_empty) flush <= 1'b0;
    end

    always_ff @(posedge w_user_clk or posedge w_user_rst) begin
        if (w_user_rst) begin
            o_overflow_cnt <= '0;
        end else if (i_rx_valid && fifo_full && (o_overflow_cnt != '1)) begin
            o_overflow_cnt <= o_overflow_cnt + 1'b1;
        end
    end

    always_ff @(posedge w_user_clk or posedge w_user_rst) begin
        if (w_user_rst) begin
            state         <= IDLE;
            o_tx_data     <= '0;
            o_tx_valid    <= 1'b0;
            tmo_cnt       <= '0;
            o_timeout_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_en) state <= READ;
                end
                READ: begin
                    o_tx_data  <= fifo_dout;
                    o_tx_valid <= 1'b1;
                    state      <= SEND;
                end
                SEND: begin
                    o_tx_valid <= 1'b0;
                    tmo_cnt    <= TW'(P_ACK_TIMEOUT - 1);
                    state      <= WAIT_LO;
                end
                WAIT_LO: begin
                    if (!i_tx_ready) begin
                        state <= WAIT_HI;
                    end else if (tmo_cnt == '0) begin
                        // TX never accepted the byte; it is dropped and we move on.
                        if (o_timeout_cnt != '1) o_timeout_cnt <= o_timeout_cnt + 1'b1;
                        state <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt - 1'b1;
                    end
                end
                WAIT_HI: begin
                    if (i_tx_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_loopback_ctrl.sv
// Bench for uart_loopback_ctrl: directed scenarios plus randomized bursts, with a
// queue-based reference of which bytes must reach TX and a behavioural TX-ready responder.
module tb_uart_loopback_ctrl;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int TMO   = 16;
    localparam int CW    = 4;
    localparam int AW    = 2;

    logic            w_user_clk = 1'b0;
    logic            w_user_rst = 1'b1;
    logic [DW-1:0]   i_rx_data  = '0;
    logic            i_rx_valid = 1'b0;
    logic [DW-1:0]   o_tx_data;
    logic            o_tx_valid;
    logic            i_tx_ready = 1'b1;
    logic            i_mode     = 1'b0;
    logic [DW-1:0]   i_term_char = 8'h0D;
    logic [AW:0]     o_fifo_level;
    logic [CW-1:0]   o_overflow_cnt;
    logic [CW-1:0]   o_timeout_cnt;
    logic            o_busy;

    uart_loopback_ctrl #(
        .P_DATA_WIDTH  (DW),
        .P_FIFO_DEPTH  (DEPTH),
        .P_ACK_TIMEOUT (TMO),
        .P_CNT_WIDTH   (CW)
    ) dut (
        .w_user_clk     (w_user_clk),
        .w_user_rst     (w_user_rst),
        .i_rx_data      (i_rx_data),
        .i_rx_valid     (i_rx_valid),
        .o_tx_data      (o_tx_data),
        .o_tx_valid     (o_tx_valid),
        .i_tx_ready     (i_tx_ready),
        .i_mode         (i_mode),
        .i_term_char    (i_term_char),
        .o_fifo_level   (o_fifo_level),
        .o_overflow_cnt (o_overflow_cnt),
        .o_timeout_cnt  (o_timeout_cnt),
        .o_busy         (o_busy)
    );

    always #5 w_user_clk = ~w_user_clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: bytes that must appear on TX, in order; plus expected counter values.
    logic [7:0] exp_q[$];
    int         ov_exp = 0;
    int         to_exp = 0;

    // TX-side model: ready falls 2 cycles after valid, stays low lo_len cycles.
    int  tx_seen = 0;
    int  rcnt    = 0;
    bit  ractive = 1'b0;
    bit  stuck   = 1'b0;
    int  lo_len  = 20;

    always @(negedge w_user_clk) begin
        logic [31:0] e;
        if (ractive) begin
            rcnt++;
            if (stuck) begin
                if (rcnt >= 2) ractive = 1'b0;
            end else begin
                if (rcnt == 2) i_tx_ready = 1'b0;
                if (rcnt >= 2 + lo_len) begin
                    i_tx_ready = 1'b1;
                    ractive    = 1'b0;
                end
            end
        end
        if (o_tx_valid) begin
            tx_seen++;
            e = 32'h1FF;
            if (exp_q.size() != 0) e = {24'h0, exp_q.pop_front()};
            chk("tx_data", {24'h0, o_tx_data}, e);
            rcnt    = 0;
            ractive = 1'b1;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge w_user_clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b, input bit expect_out);
        if (expect_out) exp_q.push_back(b);
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        tick();
        i_rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n;
        n = 0;
        while ((o_busy || !i_tx_ready || ractive) && n < max) begin
            tick();
            n++;
        end
        chk({tag, "_idle"}, 32'(n < max), 32'd1);
    endtask

    initial begin
        int t0;
        int n;
        int nb;
        bit md;
        logic [7:0] tc;
        logic [7:0] bv;

        // Reset values while reset is held
        tick(2);
        chk("rst_level", 32'(o_fifo_level), 0);
        chk("rst_valid", 32'(o_tx_valid), 0);
        chk("rst_busy",  32'(o_busy), 0);
        chk("rst_ovf",   32'(o_overflow_cnt), 0);
        chk("rst_tmo",   32'(o_timeout_cnt), 0);
        w_user_rst = 1'b0;
        tick(2);

        // 1: byte mode echo and 3-cycle latency
        t0 = tx_seen;
        exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h43);
        i_rx_data = 8'h41; i_rx_valid = 1'b1;
        tick(); chk("t1_lat1", 32'(o_tx_valid), 0);
        i_rx_data = 8'h42;
        tick(); chk("t1_lat2", 32'(o_tx_valid), 0);
        i_rx_data = 8'h43;
        tick(); i_rx_valid = 1'b0;
        chk("t1_lat3", 32'(o_tx_valid), 1);
        chk("t1_first", 32'(o_tx_data), 32'h41);
        wait_idle("t1", 300);
        chk("t1_cnt", 32'(tx_seen - t0), 3);

        // 2: line mode holds until terminator
        i_mode = 1'b1; i_term_char = 8'h0D;
        t0 = tx_seen;
        send(8'h41, 1'b0); send(8'h42, 1'b0);
        tick(10);
        chk("t2_hold_tx", 32'(tx_seen - t0), 0);
        chk("t2_hold_lvl", 32'(o_fifo_level), 2);
        exp_q.push_back(8'h41); exp_q.push_back(8'h42);
        send(8'h0D, 1'b1);
        wait_idle("t2", 300);
        chk("t2_cnt", 32'(tx_seen - t0), 3);
        t0 = tx_seen;
        send(8'h43, 1'b0);
        tick(10);
        chk("t2_pend0_tx", 32'(tx_seen - t0), 0);
        chk("t2_pend0_lvl", 32'(o_fifo_level), 1);
        exp_q.push_back(8'h43);
        send(8'h0D, 1'b1);
        wait_idle("t2b", 300);

        // 3: line mode, no terminator, overfill -> flush
        t0 = tx_seen;
        send(8'h31, 1'b1); send(8'h32, 1'b1); send(8'h33, 1'b1); send(8'h34, 1'b1);
        send(8'h35, 1'b0); ov_exp++;
        wait_idle("t3", 400);
        chk("t3_cnt", 32'(tx_seen - t0), 4);
        chk("t3_ovf", 32'(o_overflow_cnt), 32'(ov_exp));
        chk("t3_lvl", 32'(o_fifo_level), 0);
        t0 = tx_seen;
        send(8'h36, 1'b0);
        tick(10);
        chk("t3_flush_clr_tx", 32'(tx_seen - t0), 0);
        chk("t3_flush_clr_lvl", 32'(o_fifo_level), 1);
        exp_q.push_back(8'h36);
        send(8'h0D, 1'b1);
        wait_idle("t3b", 300);

        // 4: ready stuck high -> ack timeout, next byte still issued
        i_mode = 1'b0; stuck = 1'b1;
        t0 = tx_seen;
        send(8'h55, 1'b1);
        send(8'h66, 1'b1);
        tick(17);
        chk("t4_before", 32'(o_timeout_cnt), 32'(to_exp));
        tick();
        to_exp++;
        chk("t4_expire", 32'(o_timeout_cnt), 32'(to_exp));
        wait_idle("t4", 300);
        to_exp++;
        chk("t4_tmo2", 32'(o_timeout_cnt), 32'(to_exp));
        chk("t4_cnt", 32'(tx_seen - t0), 2);
        stuck = 1'b0;

        // 6: full FIFO with a read and a write in the same cycle
        lo_len = 20;
        for (int i = 0; i < 5; i++) send(8'h71 + 8'(i), 1'b1);
        chk("t6_full", 32'(o_fifo_level), DEPTH);
        n = 0;
        while (!i_tx_ready && n < 100) begin
            @(posedge w_user_clk); #1;
            n++;
        end
        chk("t6_ready_seen", 32'(n < 100), 1);
        i_rx_data = 8'h7F; i_rx_valid = 1'b1;
        @(posedge w_user_clk); #1;
        i_rx_valid = 1'b0;
        ov_exp++;
        chk("t6_lvl", 32'(o_fifo_level), DEPTH - 1);
        chk("t6_ovf", 32'(o_overflow_cnt), 32'(ov_exp));
        tick();
        wait_idle("t6", 400);

        // 7: overflow counter saturates
        for (int i = 0; i < 5; i++) send(8'h81 + 8'(i), 1'b1);
        for (int i = 0; i < 14; i++) send(8'h90 + 8'(i), 1'b0);
        ov_exp = (ov_exp + 14 > 15) ? 15 : ov_exp + 14;
        chk("t7_sat", 32'(o_overflow_cnt), 32'(ov_exp));
        wait_idle("t7", 400);
        chk("t7_sat_hold", 32'(o_overflow_cnt), 32'(ov_exp));

        // 5: async reset while in WAIT_HI with 3 bytes queued
        send(8'h91, 1'b1);
        send(8'h92, 1'b0); send(8'h93, 1'b0); send(8'h94, 1'b0);
        tick(6);
        chk("t5_queued", 32'(o_fifo_level), 3);
        #2 w_user_rst = 1'b1;
        #1;
        chk("t5_async_lvl", 32'(o_fifo_level), 0);
        chk("t5_async_valid", 32'(o_tx_valid), 0);
        chk("t5_async_ovf", 32'(o_overflow_cnt), 0);
        chk("t5_async_tmo", 32'(o_timeout_cnt), 0);
        chk("t5_async_busy", 32'(o_busy), 0);
        chk("t5_async_data", 32'(o_tx_data), 0);
        ov_exp = 0; to_exp = 0;
        exp_q.delete();
        tick(2);
        w_user_rst = 1'b0;
        t0 = tx_seen;
        tick(40);
        chk("t5_stale", 32'(tx_seen - t0), 0);
        chk("t5_lvl", 32'(o_fifo_level), 0);
        wait_idle("t5", 300);

        // Randomized bursts in both modes
        for (int b = 0; b < 30; b++) begin
            lo_len = $urandom_range(1, 6);
            md     = 1'($urandom_range(0, 1));
            tc     = 8'($urandom_range(0, 255));
            i_mode = md; i_term_char = tc;
            t0     = tx_seen;
            nb     = md ? $urandom_range(1, DEPTH - 1) : $urandom_range(1, DEPTH);
            for (int i = 0; i < nb; i++) begin
                bv = 8'($urandom_range(0, 255));
                if (md && bv == tc) bv = bv ^ 8'h80;
                tick($urandom_range(0, 2));
                send(bv, 1'b1);
            end
            if (md) begin
                tick(8);
                chk("rnd_hold_tx", 32'(tx_seen - t0), 0);
                chk("rnd_hold_lvl", 32'(o_fifo_level), 32'(nb));
                send(tc, 1'b1);
                nb++;
            end
            wait_idle("rnd", 500);
            chk("rnd_cnt", 32'(tx_seen - t0), 32'(nb));
            chk("rnd_lvl", 32'(o_fifo_level), 0);
        end
        chk("rnd_ovf", 32'(o_overflow_cnt), 32'(ov_exp));
        chk("rnd_tmo", 32'(o_timeout_cnt), 32'(to_exp));
        chk("end_q", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=done");
        $fatal(1, "bench timeout");
    end

endmodule
